// File: rtl/count_pkg.sv
// Shared definitions for the count_monitor checker and its cascade helpers.
`timescale 1ns/1ps
package count_pkg;
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int WRAP_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/count_wrap_sat.sv
// Saturating event counter; also used as a stage for higher-nibble cascades.
`timescale 1ns/1ps
module count_wrap_sat #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + WIDTH'(1);
    end
  end
endmodule

// File: rtl/count_monitor.sv
// Checks a 4-bit counter's Q against its enable/clear history; emits carry,
// match and a saturating wrap tally, and latches a sticky error on bad steps.
`timescale 1ns/1ps
module count_monitor
  import count_pkg::*;
#(
  parameter int WRAP_WIDTH = WRAP_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  count_enable,
  input  logic                  cnt_clear_n,
  input  logic [3:0]            Q,
  input  logic [3:0]            target,
  input  logic                  target_load,
  input  logic                  resync,
  output logic                  carry,
  output logic                  match,
  output logic [WRAP_WIDTH-1:0] wraps,
  output logic                  error,
  output logic                  tracking
);
  state_t     state_reg, state_next;
  logic [3:0] prev_reg, prev_next;
  logic       en_d_reg;
  logic [3:0] target_reg;
  logic [3:0] exp_q;
  logic       carry_next, match_next, error_next;

  // Q seen at this edge reflects the enable latched one edge earlier.
  assign exp_q = prev_reg + 4'(en_d_reg);

  always_comb begin
    state_next = state_reg;
    prev_next  = prev_reg;
    error_next = error;
    carry_next = 1'b0;
    match_next = 1'b0;
    if (!cnt_clear_n) begin
      state_next = SYNC;
      prev_next  = 4'h0;
    end else if (resync) begin
      state_next = SYNC;
      error_next = 1'b0;
    end else begin
      case (state_reg)
        SYNC: begin
          prev_next  = Q;
          state_next = TRACK;
        end
        TRACK: begin
          if (Q == exp_q) begin
            prev_next  = Q;
            carry_next = (prev_reg == 4'hF) && (Q == 4'h0) && en_d_reg;
            match_next = (Q == target_reg) && (Q != prev_reg);
          end else begin
            state_next = FAULT;
            error_next = 1'b1;
          end
        end
        FAULT: prev_next = Q;
        default: state_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg  <= SYNC;
      prev_reg   <= 4'h0;
      en_d_reg   <= 1'b0;
      target_reg <= 4'hF;
    end else begin
      state_reg <= state_next;
      prev_reg  <= prev_next;
      en_d_reg  <= count_enable;
      if (target_load) begin
        target_reg <= target;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      carry <= 1'b0;
      match <= 1'b0;
      error <= 1'b0;
    end else begin
      carry <= carry_next;
      match <= match_next;
      error <= error_next;
    end
  end

  assign tracking = (state_reg == TRACK);

  count_wrap_sat #(.WIDTH(WRAP_WIDTH)) u_wrap_sat (
    .clock (clock),
    .clear (clear),
    .inc   (carry_next),
    .value (wraps)
  );
endmodule

// File: tb/tb_count_monitor.sv
// Directed plus randomized bench for count_monitor against a rule-level model
// of the counter and of the checker; two instances cover 8- and 2-bit tallies.
`timescale 1ns/1ps
module tb_count_monitor;
  logic       clock = 1'b0;
  logic       clear;
  logic       count_enable;
  logic       cnt_clear_n;
  logic [3:0] Q;
  logic [3:0] target;
  logic       target_load;
  logic       resync;
  logic       carry, match, error, tracking;
  logic [7:0] wraps;
  logic       carry2, match2, error2, tracking2;
  logic [1:0] wraps2;

  always #5 clock = ~clock;

  count_monitor #(.WRAP_WIDTH(8)) dut (
    .clock(clock), .clear(clear), .count_enable(count_enable), .cnt_clear_n(cnt_clear_n),
    .Q(Q), .target(target), .target_load(target_load), .resync(resync),
    .carry(carry), .match(match), .wraps(wraps), .error(error), .tracking(tracking)
  );

  count_monitor #(.WRAP_WIDTH(2)) dut2 (
    .clock(clock), .clear(clear), .count_enable(count_enable), .cnt_clear_n(cnt_clear_n),
    .Q(Q), .target(target), .target_load(target_load), .resync(resync),
    .carry(carry2), .match(match2), .wraps(wraps2), .error(error2), .tracking(tracking2)
  );

  localparam int M_SYNC = 0, M_TRACK = 1, M_FAULT = 2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ctr, ctr_lat;
  int m_mode, m_prev, m_en_d, m_tgt, m_err, m_carry, m_match, m_wraps8, m_wraps2;
  int n_carry, n_carry2, n_match;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_SYNC; m_prev = 0; m_en_d = 0; m_tgt = 15; m_err = 0;
    m_carry = 0; m_match = 0; m_wraps8 = 0; m_wraps2 = 0;
  endtask

  // Behaviour of the checker at one rising edge, from its stated rules.
  task automatic model_edge();
    int q, expected;
    q = int'(Q);
    expected = (m_prev + m_en_d) % 16;
    m_carry = 0;
    m_match = 0;
    if (!cnt_clear_n) begin
      m_mode = M_SYNC; m_prev = 0;
    end else if (resync) begin
      m_mode = M_SYNC; m_err = 0;
    end else if (m_mode == M_SYNC) begin
      m_prev = q; m_mode = M_TRACK;
    end else if (m_mode == M_TRACK) begin
      if (q == expected) begin
        m_carry = (m_prev == 15 && q == 0 && m_en_d == 1) ? 1 : 0;
        m_match = (q == m_tgt && q != m_prev) ? 1 : 0;
        m_prev = q;
      end else begin
        m_mode = M_FAULT; m_err = 1;
      end
    end else begin
      m_prev = q;
    end
    if (m_carry == 1) begin
      if (m_wraps8 < 255) m_wraps8++;
      if (m_wraps2 < 3) m_wraps2++;
    end
    if (target_load) m_tgt = int'(target);
    m_en_d = count_enable ? 1 : 0;
  endtask

  task automatic check_all();
    check("carry", carry, m_carry);
    check("match", match, m_match);
    check("wraps", wraps, m_wraps8);
    check("error", error, m_err);
    check("tracking", tracking, (m_mode == M_TRACK) ? 1 : 0);
    check("carry2", carry2, m_carry);
    check("wraps2", wraps2, m_wraps2);
  endtask

  // One clock: counter latches at the rising edge and shows Q at the falling edge.
  task automatic cycle();
    @(posedge clock);
    ctr_lat = !cnt_clear_n ? 0 : (count_enable ? (ctr + 1) % 16 : ctr);
    model_edge();
    #1;
    check_all();
    cyc++;
    $display("cyc %0d Q=%0d en=%0b clrn=%0b rs=%0b carry=%0b match=%0b wraps=%0d/%0d err=%0b trk=%0b",
             cyc, Q, count_enable, cnt_clear_n, resync, carry, match, wraps, wraps2, error, tracking);
    n_carry += int'(carry);
    n_carry2 += int'(carry2);
    n_match += int'(match);
    @(negedge clock);
    ctr = ctr_lat;
    Q = 4'(ctr);
  endtask

  task automatic wait_q(input int v);
    int n = 0;
    while (int'(Q) != v && n < 40) begin
      cycle();
      n++;
    end
    check("wait_q", Q, v);
  endtask

  initial begin
    clear = 1'b1; count_enable = 1'b0; cnt_clear_n = 1'b1; Q = 4'h0;
    target = 4'h0; target_load = 1'b0; resync = 1'b0; ctr = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clock);
    clear = 1'b0;

    // Free-running count through one full wrap.
    count_enable = 1'b1; n_carry = 0;
    repeat (18) cycle();
    check("t1_carry_count", n_carry, 1);
    check("t1_wraps", wraps, 1);

    // Target 5 reached once, then held with enable low.
    target = 4'd5; target_load = 1'b1; cycle(); target_load = 1'b0;
    cnt_clear_n = 1'b0; cycle(); cnt_clear_n = 1'b1;
    n_match = 0;
    wait_q(5);
    count_enable = 1'b0;
    repeat (4) cycle();
    check("t2_match_count", n_match, 1);

    // Illegal jump 3 -> 7, no carry while faulted, then resync.
    count_enable = 1'b1;
    wait_q(3);
    cycle();
    ctr = 7; Q = 4'd7;
    cycle();
    check("t3_error", error, 1);
    check("t3_tracking", tracking, 0);
    n_carry = 0;
    repeat (14) cycle();
    check("t3_no_carry", n_carry, 0);
    resync = 1'b1; cycle(); resync = 1'b0;
    cycle();
    check("t3_retrack", tracking, 1);
    check("t3_error_clr", error, 0);

    // Toggling enable.
    repeat (8) begin
      count_enable = ~count_enable;
      cycle();
    end
    check("t4_no_error", error, 0);

    // Counter clear at Q=9.
    count_enable = 1'b1;
    wait_q(9);
    cnt_clear_n = 1'b0; cycle(); cnt_clear_n = 1'b1;
    repeat (3) cycle();
    check("t5_tracking", tracking, 1);
    check("t5_no_error", error, 0);

    // Asynchronous clear mid-cycle drops every output at once.
    repeat (3) cycle();
    #2 clear = 1'b1;
    #1;
    check("t6_carry", carry, 0);
    check("t6_match", match, 0);
    check("t6_wraps", wraps, 0);
    check("t6_error", error, 0);
    check("t6_tracking", tracking, 0);
    model_reset();
    check_all();
    #1 clear = 1'b0;

    // Five wraps: 2-bit tally saturates while carry keeps pulsing.
    cnt_clear_n = 1'b0; cycle(); cnt_clear_n = 1'b1;
    n_carry2 = 0;
    repeat (85) cycle();
    check("t7_carry2_count", n_carry2, 5);
    check("t7_wraps2_sat", wraps2, 3);
    check("t7_wraps8", wraps, 5);

    // Randomized traffic against the model.
    repeat (300) begin
      count_enable = 1'($urandom_range(0, 3) != 0);
      target_load = 1'($urandom_range(0, 7) == 0);
      target = 4'($urandom_range(0, 15));
      cnt_clear_n = 1'($urandom_range(0, 31) != 0);
      resync = 1'($urandom_range(0, 31) == 0);
      cycle();
      if ($urandom_range(0, 39) == 0) begin
        ctr = $urandom_range(0, 15);
        Q = 4'(ctr);
      end
    end
    target_load = 1'b0; cnt_clear_n = 1'b1; resync = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
